draw_sprite_bank: RTL and testbench
===================================

DRAW_SPRITE_BANK -- requirements
Module: draw_sprite_bank

Interface
REQ-001 Parameter N_IMG, default 6: number of image ROMs served; at least 1.
REQ-002 Parameter IMG_W, default 128: sprite width in pixels, power of two.
REQ-003 Parameter IMG_H, default 128: sprite height in pixels.
REQ-004 Parameter ROM_LAT, default 1: ROM read latency in clk cycles, from pixel_addr to rom_rgb; at least 1.
REQ-005 Parameter FRAME_DIV, default 8: frames shown per image in animation mode; at least 1.
REQ-006 Parameter KEY_RGB, default 12'hF0F: transparent colour key.
REQ-007 Derived widths: ADDR_W = $clog2(IMG_W*IMG_H); SEL_W = max(1, $clog2(N_IMG)).
REQ-008 Port clk, input, 1: the single system clock.
REQ-009 Port rst, input, 1: synchronous, active-high reset.
REQ-010 Port in, vga_if.in, bundle: upstream hcount, vcount, hsync, vsync, hblnk, vblnk, rgb.
REQ-011 Port out, vga_if.out, bundle: the same fields, delayed, with the sprite overlaid.
REQ-012 Port xpos, input, 12: sprite left edge in pixels.
REQ-013 Port ypos, input, 12: sprite top edge in pixels.
REQ-014 Port img_sel, input, SEL_W: static image index.
REQ-015 Port anim_en, input, 1: 1 selects auto-cycling through the images.
REQ-016 Port pixel_addr, output, ADDR_W: read address driven to all N_IMG ROMs, shared.
REQ-017 Port rom_rgb, input, N_IMG*12: packed ROM data; image k occupies bits [12k+11:12k].

Function
REQ-018 Frame latch: on a rising edge of in.vsync (sampled value 0, now 1), the block SHALL latch xpos, ypos and img_sel into active registers; the active registers SHALL NOT change at any other time.
REQ-019 Clamp: a latched img_sel >= N_IMG SHALL be stored as N_IMG-1.
REQ-020 Window: inside = (hcount >= xpos_a) && (hcount - xpos_a < IMG_W) && (vcount >= ypos_a) && (vcount - ypos_a < IMG_H); comparisons SHALL be made before subtraction, so no underflow wrap occurs.
REQ-021 Address: pixel_addr = (vcount - ypos_a)*IMG_W + (hcount - xpos_a), truncated to ADDR_W, registered one cycle after in; when not inside, pixel_addr SHALL hold 0.
REQ-022 Pipeline: inside, the active index and all in.* fields SHALL be delayed so that they align with rom_rgb; total latency from in to out SHALL be ROM_LAT+2 cycles for every field.
REQ-023 Output mux: out.rgb SHALL be the selected rom_rgb slice when all three hold: inside_d, pixel != KEY_RGB, and no blanking. Otherwise out.rgb SHALL be in.rgb delayed.
REQ-024 Blanking: when delayed hblnk or vblnk is 1, out.rgb SHALL be 12'h000.
REQ-025 Animation FSM states: STATIC, ANIM.
REQ-026 STATIC SHALL go to ANIM on the vsync rise where anim_en=1; ANIM SHALL go to STATIC on the vsync rise where anim_en=0. anim_en SHALL be sampled only at the vsync rise.
REQ-027 In STATIC, the active index SHALL be the latched img_sel, and frame_cnt SHALL be held at 0.
REQ-028 In ANIM, each vsync rise SHALL increment frame_cnt.
REQ-029 In ANIM, when frame_cnt = FRAME_DIV-1, frame_cnt SHALL wrap to 0 and the active index SHALL advance, wrapping from N_IMG-1 to 0.
REQ-030 Entering ANIM SHALL start the sequence from the active index already held.
REQ-031 Clipping: a sprite extending past the screen edge SHALL be truncated, with no wrap to the opposite edge.

Reset
REQ-032 While rst=1, the following SHALL be 0: all out fields, pixel_addr, every pipeline stage, xpos_a, ypos_a, the active index and frame_cnt; the FSM SHALL be in STATIC.
REQ-033 After a reset mid-frame, out SHALL be zero for ROM_LAT+2 cycles and then follow the delayed in.
REQ-034 After a reset mid-frame, image 0 at (0,0) SHALL be drawn until the first vsync rise.

Verification
REQ-035 Static draw: xpos=100, ypos=50, img_sel=2, rom_rgb slice 2 = 12'h123. At in hcount=100, vcount=50, the bench SHALL see out.rgb=12'h123 with out.hcount=100 exactly ROM_LAT+2 cycles later, and pixel_addr=0 one cycle after in.
REQ-036 Edges: at hcount=227 (relative x=127), the bench SHALL see the sprite pixel and pixel_addr=127. At hcount=228, the bench SHALL see the delayed in.rgb. At hcount=99, pixel_addr=0 and no sprite.
REQ-037 Key and blank: ROM data 12'hF0F inside the window SHALL pass the background through. hblnk=1 inside the window SHALL give out.rgb=0.
REQ-038 Tear-free: changing xpos mid-frame SHALL NOT move the sprite until after the next vsync rise. img_sel=7 with N_IMG=6 SHALL draw image 5.
REQ-039 Animation: anim_en=1 with FRAME_DIV=2 SHALL step the active index 0,0,1,1,...,5,5,0 across 12 vsync rises. anim_en=0 at a vsync rise SHALL return to img_sel.
REQ-040 Reset mid-line: rst pulsed for 1 cycle SHALL give out all-zero for ROM_LAT+2 cycles, then the delayed in with image 0 at (0,0).

Source files
------------

// File: rtl/draw_sprite_bank_if.sv
// VGA timing/pixel bundle passed between drawing stages.
// Latency: none (wiring only).
// Backpressure: none; the raster stream cannot stall.
interface vga_if;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_sprite_bank.sv
// Overlays one of N_IMG ROM sprites on the VGA stream, static or frame-animated.
// Latency: ROM_LAT+2 clk cycles from in to out for every field.
// Backpressure: none; one pixel accepted and produced every cycle.
module draw_sprite_bank #(
    parameter int          N_IMG     = 6,
    parameter int          IMG_W     = 128,
    parameter int          IMG_H     = 128,
    parameter int          ROM_LAT   = 1,
    parameter int          FRAME_DIV = 8,
    parameter logic [11:0] KEY_RGB   = 12'hF0F,
    localparam int         ADDR_W    = $clog2(IMG_W * IMG_H),
    localparam int         SEL_W     = (N_IMG > 1) ? $clog2(N_IMG) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_if.in                    in,
    vga_if.out                   out,
    input  logic [11:0]          xpos,
    input  logic [11:0]          ypos,
    input  logic [SEL_W-1:0]     img_sel,
    input  logic                 anim_en,
    output logic [ADDR_W-1:0]    pixel_addr,
    input  logic [N_IMG*12-1:0]  rom_rgb
);

    localparam int          CNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [31:0] IMG_W_U  = 32'(IMG_W);
    localparam logic [31:0] IMG_H_U  = 32'(IMG_H);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_IMG - 1);

    typedef struct packed {
        logic [11:0] hcount;
        logic [11:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

    typedef struct packed {
        vga_t             v;
        logic             win;
        logic [SEL_W-1:0] idx;
    } stage_t;

    typedef enum logic {STATIC, ANIM} state_t;

    state_t           state_q, state_d;
    logic             vsync_q;
    logic             vs_rise;
    logic [11:0]      xpos_a, ypos_a;
    logic [SEL_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SEL_W-1:0] sel_clamped;

    vga_t             in_v;
    logic [11:0]      rel_x, rel_y;
    logic             win;
    logic [ADDR_W-1:0] addr_nxt;

    stage_t           pipe [ROM_LAT+1];
    vga_t             out_q, out_nxt;
    logic [11:0]      pix;
    logic             blank;

    assign in_v    = {in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk, in.rgb};
    assign vs_rise = in.vsync & ~vsync_q;

    always_comb begin
        sel_clamped = img_sel;
        if (32'(img_sel) >= 32'(N_IMG))
            sel_clamped = IDX_LAST;
    end

    // FSM: mode changes only at a vsync rise.
    always_ff @(posedge clk) begin
        if (rst) state_q <= STATIC;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (vs_rise) begin
            case (state_q)
                STATIC:  if (anim_en)  state_d = ANIM;
                ANIM:    if (!anim_en) state_d = STATIC;
                default: state_d = STATIC;
            endcase
        end
    end

    // Frame-latched registers; nothing here moves mid-frame, so no tearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            xpos_a  <= '0;
            ypos_a  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            vsync_q <= in.vsync;
            if (vs_rise) begin
                xpos_a <= xpos;
                ypos_a <= ypos;
                if (state_q == ANIM && anim_en) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else if (state_q == STATIC && anim_en) begin
                    // Entering animation keeps the image currently shown.
                    cnt_q <= '0;
                end else begin
                    cnt_q <= '0;
                    idx_q <= sel_clamped;
                end
            end
        end
    end

    // Compare before trusting the differences so a sprite near an edge never wraps.
    always_comb begin
        rel_x    = in.hcount - xpos_a;
        rel_y    = in.vcount - ypos_a;
        win      = (in.hcount >= xpos_a) && ({20'b0, rel_x} < IMG_W_U) &&
                   (in.vcount >= ypos_a) && ({20'b0, rel_y} < IMG_H_U);
        addr_nxt = ADDR_W'(rel_y) * ADDR_W'(IMG_W) + ADDR_W'(rel_x);
    end

    // pipe[0] sits alongside pixel_addr; pipe[ROM_LAT] lines up with rom_rgb.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_addr <= '0;
            for (int i = 0; i <= ROM_LAT; i++)
                pipe[i] <= '0;
        end else begin
            pixel_addr <= win ? addr_nxt : '0;
            pipe[0]    <= '{v: in_v, win: win, idx: idx_q};
            for (int i = 1; i <= ROM_LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    always_comb begin
        pix = '0;
        for (int k = 0; k < N_IMG; k++)
            if (pipe[ROM_LAT].idx == SEL_W'(k))
                pix = rom_rgb[12*k +: 12];
    end

    always_comb begin
        blank   = pipe[ROM_LAT].v.hblnk | pipe[ROM_LAT].v.vblnk;
        out_nxt = pipe[ROM_LAT].v;
        if (blank)
            out_nxt.rgb = 12'h000;
        else if (pipe[ROM_LAT].win && pix != KEY_RGB)
            out_nxt.rgb = pix;
    end

    always_ff @(posedge clk) begin
        if (rst) out_q <= '0;
        else     out_q <= out_nxt;
    end

    assign out.hcount = out_q.hcount;
    assign out.vcount = out_q.vcount;
    assign out.hsync  = out_q.hsync;
    assign out.vsync  = out_q.vsync;
    assign out.hblnk  = out_q.hblnk;
    assign out.vblnk  = out_q.vblnk;
    assign out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_sprite_bank.sv
// Directed bench for draw_sprite_bank with a registered ROM model (ROM_LAT=1).
module tb_draw_sprite_bank;

    localparam int N_IMG  = 6;
    localparam int SEL_W  = 3;
    localparam int ADDR_W = 14;
    localparam logic [11:0] BASE [0:5] = '{12'h200, 12'h300, 12'h123, 12'h400, 12'h500, 12'h600};
    localparam int SEQ [0:12] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 0};

    logic                clk = 1'b0;
    logic                rst;
    logic [11:0]         xpos, ypos;
    logic [SEL_W-1:0]    img_sel;
    logic                anim_en;
    logic [ADDR_W-1:0]   pixel_addr;
    logic [N_IMG*12-1:0] rom_rgb;

    int checks = 0;
    int errors = 0;

    vga_if vin();
    vga_if vout();

    draw_sprite_bank #(
        .N_IMG(N_IMG), .IMG_W(128), .IMG_H(128), .ROM_LAT(1),
        .FRAME_DIV(2), .KEY_RGB(12'hF0F)
    ) dut (
        .clk(clk), .rst(rst), .in(vin), .out(vout),
        .xpos(xpos), .ypos(ypos), .img_sel(img_sel), .anim_en(anim_en),
        .pixel_addr(pixel_addr), .rom_rgb(rom_rgb)
    );

    always #5 clk = ~clk;

    // ROM model: image k holds BASE[k]+addr, with the colour key at address 5.
    always @(posedge clk) begin
        for (int k = 0; k < N_IMG; k++)
            rom_rgb[12*k +: 12] <= (pixel_addr == 14'd5) ? 12'hF0F : BASE[k] + pixel_addr[11:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic px(input logic [11:0] h, input logic [11:0] v, input logic [11:0] bg,
                      input logic hb, input logic vs);
        vin.hcount = h;
        vin.vcount = v;
        vin.rgb    = bg;
        vin.hblnk  = hb;
        vin.vblnk  = 1'b0;
        vin.hsync  = 1'b0;
        vin.vsync  = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        px(12'd1000, 12'd700, 12'hABC, 1'b0, 1'b0);
    endtask

    task automatic vrise();
        idle();
        px(12'd1000, 12'd700, 12'hABC, 1'b0, 1'b1);
        idle();
    endtask

    task automatic probe(input string tag, input logic [11:0] h, input logic [11:0] v,
                         input logic [11:0] bg, input logic hb,
                         input logic [31:0] ea, input logic [11:0] er);
        px(h, v, bg, hb, 1'b0);
        check({tag, "_addr"}, 32'(pixel_addr), ea);
        idle();
        idle();
        check({tag, "_rgb"}, 32'(vout.rgb), 32'(er));
    endtask

    initial begin
        rst = 1'b1; xpos = 12'd0; ypos = 12'd0; img_sel = '0; anim_en = 1'b0;
        px(12'd5, 12'd5, 12'h111, 1'b0, 1'b0);
        px(12'd5, 12'd5, 12'h111, 1'b0, 1'b0);
        px(12'd5, 12'd5, 12'h111, 1'b0, 1'b0);
        check("rst_rgb", 32'(vout.rgb), 32'h0);
        check("rst_hcount", 32'(vout.hcount), 32'h0);
        check("rst_vcount", 32'(vout.vcount), 32'h0);
        check("rst_addr", 32'(pixel_addr), 32'h0);
        rst = 1'b0;

        // Before any vsync: image 0 at (0,0).
        probe("boot_img0", 12'd3, 12'd1, 12'h0C3, 1'b0, 32'd131, 12'h283);

        xpos = 12'd100; ypos = 12'd50; img_sel = 3'd2;
        vrise();
        probe("origin", 12'd100, 12'd50, 12'h0C3, 1'b0, 32'd0, 12'h123);
        check("origin_hcount", 32'(vout.hcount), 32'd100);
        probe("right_in", 12'd227, 12'd50, 12'h0C3, 1'b0, 32'd127, 12'h1A2);
        probe("right_out", 12'd228, 12'd50, 12'h0D4, 1'b0, 32'd0, 12'h0D4);
        probe("left_out", 12'd99, 12'd50, 12'h0E5, 1'b0, 32'd0, 12'h0E5);
        probe("key", 12'd105, 12'd50, 12'h0F6, 1'b0, 32'd5, 12'h0F6);
        probe("hblank", 12'd101, 12'd50, 12'h777, 1'b1, 32'd1, 12'h000);
        probe("bottom_in", 12'd100, 12'd177, 12'h0C3, 1'b0, 32'd16256, 12'h0A3);
        probe("bottom_out", 12'd100, 12'd178, 12'h0B2, 1'b0, 32'd0, 12'h0B2);

        // Mid-frame changes wait for the next vsync rise.
        xpos = 12'd300; img_sel = 3'd7;
        probe("tear_hold", 12'd100, 12'd50, 12'h0C3, 1'b0, 32'd0, 12'h123);
        vrise();
        probe("clamp_img5", 12'd300, 12'd50, 12'h0C3, 1'b0, 32'd0, 12'h600);
        probe("old_pos_gone", 12'd100, 12'd50, 12'h0C7, 1'b0, 32'd0, 12'h0C7);

        // Near the right limit the window must not wrap to the left edge.
        xpos = 12'd4000; ypos = 12'd0;
        vrise();
        probe("no_wrap", 12'd10, 12'd0, 12'h0A5, 1'b0, 32'd0, 12'h0A5);
        probe("far_right", 12'd4001, 12'd2, 12'h0A5, 1'b0, 32'd257, 12'h701);

        xpos = 12'd0; ypos = 12'd0; img_sel = 3'd0;
        vrise();
        probe("static0", 12'd0, 12'd0, 12'h0C3, 1'b0, 32'd0, 12'h200);
        anim_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            vrise();
            probe($sformatf("anim%0d", i), 12'd0, 12'd0, 12'h0C3, 1'b0, 32'd0, BASE[SEQ[i]]);
        end
        anim_en = 1'b0; img_sel = 3'd3; xpos = 12'd200; ypos = 12'd100;
        vrise();
        probe("anim_off", 12'd200, 12'd100, 12'h0C3, 1'b0, 32'd0, 12'h400);
        probe("anim_off_bg", 12'd0, 12'd0, 12'h0C8, 1'b0, 32'd0, 12'h0C8);

        // One-cycle reset in the middle of a line.
        px(12'd10, 12'd100, 12'h0C3, 1'b0, 1'b0);
        rst = 1'b1;
        px(12'd20, 12'd100, 12'h111, 1'b0, 1'b0);
        rst = 1'b0;
        check("mid_rst_rgb0", 32'(vout.rgb), 32'h0);
        check("mid_rst_hc0", 32'(vout.hcount), 32'h0);
        check("mid_rst_addr0", 32'(pixel_addr), 32'h0);
        px(12'd2, 12'd1, 12'h0C3, 1'b0, 1'b0);
        check("mid_rst_addr", 32'(pixel_addr), 32'd130);
        check("mid_rst_rgb1", 32'(vout.rgb), 32'h0);
        check("mid_rst_hc1", 32'(vout.hcount), 32'h0);
        idle();
        check("mid_rst_rgb2", 32'(vout.rgb), 32'h0);
        check("mid_rst_hc2", 32'(vout.hcount), 32'h0);
        idle();
        check("mid_rst_img0", 32'(vout.rgb), 32'h282);
        check("mid_rst_hc3", 32'(vout.hcount), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
